// File: rtl/alu_ctl_issue.sv
// alu_ctl_issue -- RV32I decode-and-issue stage.
//
// Decodes an instruction into the ALU control code, the operand selects, the
// sign-extended immediate and the branch info. Each decoded entry is held in a
// main output register (M), which a one-entry skid register (S) backs up.
// in_ready comes straight from the state register, so it never depends
// combinationally on out_ready.
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   flush         synchronous kill of every held entry, including any accept
//                 in the same cycle
//   in_valid/in_ready, in_instr, in_pc          fetch-side handshake and payload
//   out_valid/out_ready                         execute-side handshake
//   out_alu_ctl   0000 ADD, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR,
//                 0101 SRL, 0110 OR, 0111 AND, 1000 SUB, 1101 SRA
//   out_src_a     00 rs1, 01 pc, 10 zero
//   out_src_b     0 rs2, 1 immediate
//   out_imm       sign-extended immediate (0 for R-type)
//   out_branch, out_br_cond   conditional branch flag and its funct3
//   out_illegal   instruction is outside the supported subset
//   out_pc        PC carried with the entry
module alu_ctl_issue #(
  parameter logic [3:0] ILLEGAL_CTL = 4'b0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_alu_ctl,
  output logic [1:0]  out_src_a,
  output logic        out_src_b,
  output logic [31:0] out_imm,
  output logic        out_branch,
  output logic [2:0]  out_br_cond,
  output logic        out_illegal,
  output logic [31:0] out_pc
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  typedef struct packed {
    logic [3:0]  alu_ctl;
    logic [1:0]  src_a;
    logic        src_b;
    logic [31:0] imm;
    logic        branch;
    logic [2:0]  br_cond;
    logic        illegal;
    logic [31:0] pc;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  function automatic entry_t decode(input logic [31:0] instr, input logic [31:0] pc);
    entry_t     e;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       bad;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    f3    = instr[14:12];
    f7    = instr[31:25];
    imm_i = {{20{instr[31]}}, instr[31:20]};
    imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    imm_u = {instr[31:12], 12'h000};
    imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    e     = '0;
    e.pc  = pc;
    bad   = 1'b0;
    case (instr[6:0])
      OPC_OP: begin
        // funct7[5] selects SUB/SRA; only ADD and SR* have that alternate form.
        e.alu_ctl = {f7[5], f3};
        if (f7 == 7'b0100000) bad = !((f3 == 3'b000) || (f3 == 3'b101));
        else                  bad = (f7 != 7'b0000000);
      end
      OPC_OPIMM: begin
        e.src_b   = 1'b1;
        e.imm     = imm_i;
        e.alu_ctl = {1'b0, f3};
        // Only shifts interpret funct7; the other ops use those bits as immediate.
        if (f3 == 3'b001) begin
          bad = (f7 != 7'b0000000);
        end else if (f3 == 3'b101) begin
          bad       = (f7 != 7'b0000000) && (f7 != 7'b0100000);
          e.alu_ctl = {f7[5], f3};
        end
      end
      OPC_LOAD, OPC_JALR: begin
        e.src_b = 1'b1;
        e.imm   = imm_i;
      end
      OPC_STORE: begin
        e.src_b = 1'b1;
        e.imm   = imm_s;
      end
      OPC_BRANCH: begin
        e.imm     = imm_b;
        e.branch  = 1'b1;
        e.br_cond = f3;
        case (f3[2:1])
          2'b00:   e.alu_ctl = 4'b1000;
          2'b10:   e.alu_ctl = 4'b0010;
          2'b11:   e.alu_ctl = 4'b0011;
          default: bad = 1'b1;
        endcase
      end
      OPC_JAL: begin
        e.src_a = 2'b01;
        e.src_b = 1'b1;
        e.imm   = imm_j;
      end
      OPC_AUIPC: begin
        e.src_a = 2'b01;
        e.src_b = 1'b1;
        e.imm   = imm_u;
      end
      OPC_LUI: begin
        e.src_a = 2'b10;
        e.src_b = 1'b1;
        e.imm   = imm_u;
      end
      default: bad = 1'b1;
    endcase
    // An illegal entry still flows downstream, carrying only its PC.
    if (bad) begin
      e         = '0;
      e.alu_ctl = ILLEGAL_CTL;
      e.illegal = 1'b1;
      e.pc      = pc;
    end
    return e;
  endfunction

  state_t state_q, state_d;
  entry_t m_q, m_d;
  entry_t s_q, s_d;
  entry_t dec;
  logic   accept;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid && in_ready;
  assign dec       = decode(in_instr, in_pc);

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      state_d = EMPTY;
      m_d     = '0;
      s_d     = '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            m_d     = dec;
            state_d = ONE;
          end
        end
        ONE: begin
          if (accept && out_ready) begin
            m_d = dec;
          end else if (accept) begin
            // M is stalled; park the new entry so fetch sees in_ready drop next cycle.
            s_d     = dec;
            state_d = TWO;
          end else if (out_ready) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (out_ready) begin
            m_d     = s_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  assign out_alu_ctl = m_q.alu_ctl;
  assign out_src_a   = m_q.src_a;
  assign out_src_b   = m_q.src_b;
  assign out_imm     = m_q.imm;
  assign out_branch  = m_q.branch;
  assign out_br_cond = m_q.br_cond;
  assign out_illegal = m_q.illegal;
  assign out_pc      = m_q.pc;

endmodule

// File: tb/tb_alu_ctl_issue.sv
// Testbench for alu_ctl_issue: a driver issues directed and random
// instructions and queues the expected decode of every accepted one; a monitor
// pops and compares each entry that EX consumes.
module tb_alu_ctl_issue;

  localparam logic [3:0] ILL = 4'b0000;

  typedef struct packed {
    logic [3:0]  ctl;
    logic [1:0]  sa;
    logic        sb;
    logic [31:0] imm;
    logic        br;
    logic [2:0]  cond;
    logic        ill;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alu_ctl;
  logic [1:0]  out_src_a;
  logic        out_src_b;
  logic [31:0] out_imm;
  logic        out_branch;
  logic [2:0]  out_br_cond;
  logic        out_illegal;
  logic [31:0] out_pc;

  alu_ctl_issue #(.ILLEGAL_CTL(ILL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_alu_ctl(out_alu_ctl), .out_src_a(out_src_a), .out_src_b(out_src_b),
    .out_imm(out_imm), .out_branch(out_branch), .out_br_cond(out_br_cond),
    .out_illegal(out_illegal), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        sb_q[$];
  logic        pend = 1'b0;
  logic [31:0] pc_ctr = 32'h0000_1000;

  // Reference decode written from the instruction-set rules using integer
  // arithmetic for the immediates.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int   s, f3, f7, imm_i, imm_s, imm_b, imm_j, imm_u;
    int   br_map[8] = '{8, 8, -1, -1, 2, 2, 3, 3};
    logic ok;
    s     = w[31] ? -1 : 0;
    f3    = int'(w[14:12]);
    f7    = int'(w[31:25]);
    imm_i = s * 2048 + int'(w[30:20]);
    imm_s = s * 2048 + int'(w[30:25]) * 32 + int'(w[11:7]);
    imm_b = s * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    imm_j = s * 1048576 + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    imm_u = int'(w[31:12]) * 4096;
    e    = '0;
    e.pc = pc;
    ok   = 1'b1;
    case (w[6:0])
      7'h33: begin
        if (f7 == 0)                    e.ctl = 4'(f3);
        else if (f7 == 32 && f3 == 0)   e.ctl = 4'd8;
        else if (f7 == 32 && f3 == 5)   e.ctl = 4'd13;
        else                            ok = 1'b0;
      end
      7'h13: begin
        e.sb = 1'b1; e.imm = imm_i;
        if (f3 == 1)      begin e.ctl = 4'd1; ok = (f7 == 0); end
        else if (f3 == 5) begin
          if (f7 == 0)       e.ctl = 4'd5;
          else if (f7 == 32) e.ctl = 4'd13;
          else               ok = 1'b0;
        end else             e.ctl = 4'(f3);
      end
      7'h03, 7'h67: begin e.sb = 1'b1; e.imm = imm_i; end
      7'h23:        begin e.sb = 1'b1; e.imm = imm_s; end
      7'h63: begin
        e.imm = imm_b; e.br = 1'b1; e.cond = 3'(f3);
        if (br_map[f3] < 0) ok = 1'b0;
        else                e.ctl = 4'(br_map[f3]);
      end
      7'h6F: begin e.sa = 2'd1; e.sb = 1'b1; e.imm = imm_j; end
      7'h17: begin e.sa = 2'd1; e.sb = 1'b1; e.imm = imm_u; end
      7'h37: begin e.sa = 2'd2; e.sb = 1'b1; e.imm = imm_u; end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      e = '0; e.ctl = ILL; e.ill = 1'b1; e.pc = pc;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F, 7'h17, 7'h37, 7'h00};
    logic [31:0] w;
    int          k;
    w = $urandom;
    k = $urandom_range(9);
    w[6:0] = (k == 9) ? 7'($urandom) : ops[k];
    case ($urandom_range(3))
      0:       w[31:25] = 7'h00;
      1:       w[31:25] = 7'h20;
      default: ;
    endcase
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // One clock of stimulus: drive inputs now (just after a rising edge), queue
  // the expected entry if it will be kept, then advance to just after the next edge.
  task automatic cycle(input logic v, input logic [31:0] w, input logic ordy,
                       input logic fl, output logic acc);
    in_valid  = v;
    in_instr  = w;
    in_pc     = pc_ctr;
    out_ready = ordy;
    flush     = fl;
    acc       = v && in_ready && !fl;
    pend      = acc;
    if (acc) sb_q.push_back(model(w, pc_ctr));
    if (v && in_ready) pc_ctr += 4;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0, a);
  endtask

  task automatic send_retry(input logic [31:0] w, input string name);
    logic a;
    int   tries;
    a = 1'b0;
    tries = 0;
    while (!a && tries < 10) begin
      cycle(1'b1, w, 1'b1, 1'b0, a);
      tries++;
    end
    chk({name, "_accepted"}, {31'h0, a}, 32'h1);
  endtask

  // Monitor: occupancy-based handshake checks and in-order entry comparison.
  initial begin : monitor
    int   occ;
    exp_t e, got;
    forever begin
      @(negedge clk);
      if (!rst) begin
        occ = sb_q.size() - (pend ? 1 : 0);
        chk("in_ready", {31'h0, in_ready}, {31'h0, occ < 2});
        chk("out_valid", {31'h0, out_valid}, {31'h0, occ > 0});
        if (out_valid && out_ready) begin
          got = {out_alu_ctl, out_src_a, out_src_b, out_imm, out_branch,
                 out_br_cond, out_illegal, out_pc};
          n_checks++;
          if (sb_q.size() == 0) begin
            n_errors++;
            $display("FAIL entry: got unexpected %h expected none", got);
          end else begin
            e = sb_q.pop_front();
            if (got !== e) begin
              n_errors++;
              $display("FAIL entry: got %h expected %h", got, e);
            end
          end
        end
        if (flush) sb_q.delete();
      end
    end
  end

  initial begin : driver
    logic a;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_ctl", {28'h0, out_alu_ctl}, 32'h0);
    chk("rst_imm", out_imm, 32'h0);
    chk("rst_pc", out_pc, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Spec vectors, each checked the cycle after acceptance.
    cycle(1'b1, 32'h002081B3, 1'b1, 1'b0, a);
    chk("add_valid", {31'h0, out_valid}, 32'h1);
    chk("add_ctl", {28'h0, out_alu_ctl}, 32'h0);
    chk("add_srca", {30'h0, out_src_a}, 32'h0);
    chk("add_srcb", {31'h0, out_src_b}, 32'h0);
    chk("add_imm", out_imm, 32'h0);
    cycle(1'b1, 32'h4032D293, 1'b1, 1'b0, a);
    chk("srai_ctl", {28'h0, out_alu_ctl}, 32'hD);
    chk("srai_srcb", {31'h0, out_src_b}, 32'h1);
    chk("srai_imm", out_imm, 32'h403);
    chk("srai_ill", {31'h0, out_illegal}, 32'h0);
    cycle(1'b1, 32'h4232D293, 1'b1, 1'b0, a);
    chk("badf7_ill", {31'h0, out_illegal}, 32'h1);
    chk("badf7_ctl", {28'h0, out_alu_ctl}, {28'h0, ILL});
    chk("badf7_imm", out_imm, 32'h0);
    cycle(1'b1, 32'h0020E463, 1'b1, 1'b0, a);
    chk("bltu_ctl", {28'h0, out_alu_ctl}, 32'h3);
    chk("bltu_br", {31'h0, out_branch}, 32'h1);
    chk("bltu_cond", {29'h0, out_br_cond}, 32'h6);
    chk("bltu_imm", out_imm, 32'h8);
    cycle(1'b1, 32'h123450B7, 1'b1, 1'b0, a);
    chk("lui_srca", {30'h0, out_src_a}, 32'h2);
    chk("lui_imm", out_imm, 32'h12345000);
    idle(2);

    // Stream of 4 with out_ready low for 3 cycles.
    cycle(1'b1, 32'h00500093, 1'b0, 1'b0, a);
    cycle(1'b1, 32'h40208133, 1'b0, 1'b0, a);
    chk("stream_ready_drop", {31'h0, in_ready}, 32'h0);
    cycle(1'b1, 32'h0020C1B3, 1'b0, 1'b0, a);
    send_retry(32'h0020C1B3, "stream3");
    send_retry(32'h00112223, "stream4");
    idle(4);

    // Flush with M and S full, in_valid high.
    cycle(1'b1, 32'h00100093, 1'b0, 1'b0, a);
    cycle(1'b1, 32'h00200113, 1'b0, 1'b0, a);
    cycle(1'b1, 32'h00300193, 1'b0, 1'b1, a);
    chk("flush2_valid", {31'h0, out_valid}, 32'h0);
    chk("flush2_ready", {31'h0, in_ready}, 32'h1);
    // Flush from ONE while an accept would otherwise happen.
    cycle(1'b1, 32'h00400213, 1'b0, 1'b0, a);
    cycle(1'b1, 32'h00500293, 1'b1, 1'b1, a);
    chk("flush1_valid", {31'h0, out_valid}, 32'h0);
    idle(3);

    // Asynchronous reset while in TWO.
    cycle(1'b1, 32'h00600313, 1'b0, 1'b0, a);
    cycle(1'b1, 32'h00700393, 1'b0, 1'b0, a);
    in_valid = 1'b0;
    pend = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'h0, out_valid}, 32'h0);
    chk("arst_ready", {31'h0, in_ready}, 32'h1);
    chk("arst_pc", out_pc, 32'h0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    cycle(1'b1, 32'h002081B3, 1'b1, 1'b0, a);
    chk("post_rst_valid", {31'h0, out_valid}, 32'h1);
    chk("post_rst_ctl", {28'h0, out_alu_ctl}, 32'h0);
    idle(2);

    // Random traffic with random back-pressure and occasional flushes.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(3) != 0), rand_instr(), ($urandom_range(2) != 0),
            ($urandom_range(39) == 0), a);
    end
    idle(5);
    chk("drained", sb_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
